// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole playfield: cell state encoding,
// per-cell colour constants and a saturating add used by the hit/miss counters.
package mole_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_UP    = 2'd1,
        CELL_FLASH = 2'd2
    } cell_state_e;

    // 3-bit RGB tile colours, bit 2 = red, bit 1 = green, bit 0 = blue
    localparam logic [2:0] RGB_EMPTY     = 3'b010; // green
    localparam logic [2:0] RGB_EMPTY_SEL = 3'b001; // blue
    localparam logic [2:0] RGB_UP        = 3'b110; // yellow
    localparam logic [2:0] RGB_UP_SEL    = 3'b101; // magenta
    localparam logic [2:0] RGB_FLASH     = 3'b100; // red

    // a + b, clamped to max (operands are small, so the 32-bit sum cannot wrap)
    function automatic int unsigned sat_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned max);
        int unsigned sum;
        sum = a + b;
        return (sum > max) ? max : sum;
    endfunction

endpackage

// File: rtl/mole_cell.sv
// One playfield cell: EMPTY/UP/FLASH state machine, flash timer, optional
// mole lifetime timer and the combinational colour for this cell.
// Optional feature: MOLE_TIMEOUT_EN adds the life counter and the expiry path.
module mole_cell
    import mole_pkg::*;
#(
`ifdef MOLE_TIMEOUT_EN
    parameter int LIFE_CYCLES  = 50000000,
`endif
    parameter int FLASH_CYCLES = 12000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spawn_hit,   // accepted spawn targeting this cell
    input  logic        strike_hit,  // strike while this cell is selected
    input  logic        selected,
    output cell_state_e state,
    output logic        expired,     // mole times out this cycle (not struck)
    output logic [2:0]  rgb
);

    localparam int FLASH_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_CYCLES - 1);

    logic [FLASH_W-1:0] flash_cnt;

`ifdef MOLE_TIMEOUT_EN
    localparam int LIFE_W = (LIFE_CYCLES > 1) ? $clog2(LIFE_CYCLES) : 1;
    localparam logic [LIFE_W-1:0] LIFE_LAST = LIFE_W'(LIFE_CYCLES - 1);

    logic [LIFE_W-1:0] life_cnt;

    // A strike in the final life cycle wins over the expiry
    assign expired = (state == CELL_UP) && (life_cnt == LIFE_LAST) && !strike_hit;
`else
    assign expired = 1'b0;
`endif

    // Cell state machine with its flash and life timers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CELL_EMPTY;
            flash_cnt <= '0;
`ifdef MOLE_TIMEOUT_EN
            life_cnt  <= '0;
`endif
        end else begin
            case (state)
                CELL_EMPTY: begin
                    if (spawn_hit) begin
                        state <= CELL_UP;
`ifdef MOLE_TIMEOUT_EN
                        life_cnt <= '0;
`endif
                    end
                end
                CELL_UP: begin
                    if (strike_hit) begin
                        state     <= CELL_FLASH;
                        flash_cnt <= '0;
                    end
`ifdef MOLE_TIMEOUT_EN
                    else if (life_cnt == LIFE_LAST) begin
                        state <= CELL_EMPTY;
                    end else begin
                        life_cnt <= life_cnt + LIFE_W'(1);
                    end
`endif
                end
                CELL_FLASH: begin
                    if (flash_cnt == FLASH_LAST) begin
                        state <= CELL_EMPTY;
                    end else begin
                        flash_cnt <= flash_cnt + FLASH_W'(1);
                    end
                end
                default: state <= CELL_EMPTY;
            endcase
        end
    end

    // Colour for the current state and selection
    always_comb begin
        rgb = RGB_FLASH;
        case (state)
            CELL_EMPTY: rgb = selected ? RGB_EMPTY_SEL : RGB_EMPTY;
            CELL_UP:    rgb = selected ? RGB_UP_SEL : RGB_UP;
            default:    rgb = RGB_FLASH;
        endcase
    end

endmodule

// File: rtl/mole_grid_ctrl.sv
// Whack-a-mole playfield controller: selection cursor, strike edge detection,
// spawn decode, saturating score/miss counters and the registered RGB bus.
// Optional feature: MOLE_TIMEOUT_EN enables mole expiry (LIFE_CYCLES parameter).
module mole_grid_ctrl
    import mole_pkg::*;
#(
    parameter int N_CELLS      = 9,
    parameter int IDX_W        = 4,
`ifdef MOLE_TIMEOUT_EN
    parameter int LIFE_CYCLES  = 50000000,
`endif
    parameter int FLASH_CYCLES = 12000000,
    parameter int SCORE_W      = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   spawn,
    input  logic [IDX_W-1:0]       spawn_idx,
    output logic                   spawn_ack,
    input  logic                   move_next,
    input  logic                   move_prev,
    input  logic                   golpe,
    output logic [IDX_W-1:0]       sel_idx,
    output logic                   hit,
    output logic [SCORE_W-1:0]     score,
    output logic [SCORE_W-1:0]     misses,
    output logic [3*N_CELLS-1:0]   rgb
);

    localparam int unsigned SAT_MAX = (32'd1 << SCORE_W) - 32'd1;

    // Handshake: spawn is a single-cycle request with no back-pressure; it is
    // accepted when spawn_idx names an EMPTY cell, and spawn_ack pulses for one
    // cycle on the following clock. A rejected request is dropped, never retried.

    logic                 golpe_q;
    logic                 strike;
    cell_state_e          cell_state [N_CELLS];
    logic [N_CELLS-1:0]   selected;
    logic [N_CELLS-1:0]   spawn_hit;
    logic [N_CELLS-1:0]   strike_hit;
    logic [N_CELLS-1:0]   expired;
    logic [3*N_CELLS-1:0] rgb_d;
    cell_state_e          sel_state;
    int unsigned          exp_count;
    logic                 hit_d;
    logic                 miss_strike;
    logic [IDX_W-1:0]     sel_next;

    assign strike = golpe & ~golpe_q;

    for (genvar k = 0; k < N_CELLS; k++) begin : g_cell
        assign selected[k]   = (sel_idx == IDX_W'(k));
        // Equality with an in-range k also rejects spawn_idx >= N_CELLS
        assign spawn_hit[k]  = spawn && (spawn_idx == IDX_W'(k)) && (cell_state[k] == CELL_EMPTY);
        assign strike_hit[k] = strike && selected[k];

        mole_cell #(
`ifdef MOLE_TIMEOUT_EN
            .LIFE_CYCLES  (LIFE_CYCLES),
`endif
            .FLASH_CYCLES (FLASH_CYCLES)
        ) u_cell (
            .clk        (clk),
            .reset_n    (reset_n),
            .spawn_hit  (spawn_hit[k]),
            .strike_hit (strike_hit[k]),
            .selected   (selected[k]),
            .state      (cell_state[k]),
            .expired    (expired[k]),
            .rgb        (rgb_d[3*k +: 3])
        );
    end

    // State of the selected cell and the number of cells expiring this cycle
    always_comb begin
        sel_state = CELL_EMPTY;
        exp_count = 0;
        for (int k = 0; k < N_CELLS; k++) begin
            if (selected[k]) sel_state = cell_state[k];
            exp_count = exp_count + 32'(expired[k]);
        end
        hit_d       = strike && (sel_state == CELL_UP);
        miss_strike = strike && (sel_state == CELL_EMPTY);
    end

    // Cursor step with wrap; opposing pulses cancel
    always_comb begin
        sel_next = sel_idx;
        if (move_next && !move_prev) begin
            sel_next = (sel_idx == IDX_W'(N_CELLS - 1)) ? '0 : sel_idx + IDX_W'(1);
        end else if (move_prev && !move_next) begin
            sel_next = (sel_idx == '0) ? IDX_W'(N_CELLS - 1) : sel_idx - IDX_W'(1);
        end
    end

    // Cursor, strike history, pulses, counters and the colour register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            golpe_q   <= 1'b0;
            sel_idx   <= '0;
            hit       <= 1'b0;
            spawn_ack <= 1'b0;
            score     <= '0;
            misses    <= '0;
            for (int k = 0; k < N_CELLS; k++) begin
                rgb[3*k +: 3] <= (k == 0) ? RGB_EMPTY_SEL : RGB_EMPTY;
            end
        end else begin
            golpe_q   <= golpe;
            sel_idx   <= sel_next;
            hit       <= hit_d;
            spawn_ack <= |spawn_hit;
            score     <= SCORE_W'(sat_add(32'(score), 32'(hit_d), SAT_MAX));
            misses    <= SCORE_W'(sat_add(32'(misses), 32'(miss_strike) + exp_count, SAT_MAX));
            rgb       <= rgb_d;
        end
    end

endmodule

// File: tb/tb_mole_grid_ctrl.sv
// Bench for mole_grid_ctrl: directed scenarios plus random play, every cycle
// compared against a timestamp-based playfield model.
module tb_mole_grid_ctrl;

    localparam int N     = 4;
    localparam int IW    = 3;
    localparam int LIFE  = 8;
    localparam int FLASH = 4;
    localparam int SW    = 4;
    localparam int SMAX  = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic spawn = 1'b0;
    logic [IW-1:0] spawn_idx = '0;
    logic move_next = 1'b0;
    logic move_prev = 1'b0;
    logic golpe = 1'b0;
    logic spawn_ack;
    logic [IW-1:0] sel_idx;
    logic hit;
    logic [SW-1:0] score;
    logic [SW-1:0] misses;
    logic [3*N-1:0] rgb;

    int checks = 0;
    int failures = 0;

    // model: 0 empty, 1 up, 2 flash; dl = cycle in which the cell leaves its state
    int st [N];
    int dl [N];
    int cyc = 0;
    int m_sel, m_score, m_miss;
    bit m_gq, m_hit, m_ack;
    logic [3*N-1:0] m_rgb;
    logic [3*N-1:0] rst_rgb;
    int hit_seen = 0;

    mole_grid_ctrl #(
        .N_CELLS      (N),
        .IDX_W        (IW),
`ifdef MOLE_TIMEOUT_EN
        .LIFE_CYCLES  (LIFE),
`endif
        .FLASH_CYCLES (FLASH),
        .SCORE_W      (SW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .spawn     (spawn),
        .spawn_idx (spawn_idx),
        .spawn_ack (spawn_ack),
        .move_next (move_next),
        .move_prev (move_prev),
        .golpe     (golpe),
        .sel_idx   (sel_idx),
        .hit       (hit),
        .score     (score),
        .misses    (misses),
        .rgb       (rgb)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] colour(input int s, input bit on);
        case (s)
            0:       return on ? 3'b001 : 3'b010;
            1:       return on ? 3'b101 : 3'b110;
            default: return 3'b100;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            st[k] = 0;
            dl[k] = 0;
        end
        m_sel = 0; m_score = 0; m_miss = 0;
        m_gq = 0; m_hit = 0; m_ack = 0;
        m_rgb = rst_rgb;
    endtask

    // one clock: predict, let the DUT clock, compare, drop pulse inputs
    task automatic tick();
        bit strike;
        bit acc;
        int miss_n;
        strike = golpe && !m_gq;
        m_hit  = strike && (st[m_sel] == 1);
        miss_n = (strike && st[m_sel] == 0) ? 1 : 0;
        for (int k = 0; k < N; k++) m_rgb[3*k +: 3] = colour(st[k], k == m_sel);
        acc = spawn && (int'(spawn_idx) < N) && (st[spawn_idx] == 0);
        m_ack = acc;
        for (int k = 0; k < N; k++) begin
            if (st[k] == 1) begin
                if (strike && k == m_sel) begin
                    st[k] = 2;
                    dl[k] = cyc + FLASH;
                end
`ifdef MOLE_TIMEOUT_EN
                else if (cyc == dl[k]) begin
                    st[k] = 0;
                    miss_n++;
                end
`endif
            end else if (st[k] == 2) begin
                if (cyc == dl[k]) st[k] = 0;
            end else if (acc && int'(spawn_idx) == k) begin
                st[k] = 1;
                dl[k] = cyc + LIFE;
            end
        end
        if (move_next && !move_prev) m_sel = (m_sel + 1) % N;
        else if (move_prev && !move_next) m_sel = (m_sel + N - 1) % N;
        m_gq = golpe;
        m_score = (m_score + int'(m_hit) > SMAX) ? SMAX : m_score + int'(m_hit);
        m_miss  = (m_miss + miss_n > SMAX) ? SMAX : m_miss + miss_n;
        cyc++;
        @(posedge clk);
        #1;
        if (hit) hit_seen++;
        check("hit", 32'(hit), 32'(m_hit));
        check("spawn_ack", 32'(spawn_ack), 32'(m_ack));
        check("sel_idx", 32'(sel_idx), 32'(m_sel));
        check("score", 32'(score), 32'(m_score));
        check("misses", 32'(misses), 32'(m_miss));
        check("rgb", 32'(rgb), 32'(m_rgb));
        spawn = 1'b0;
        move_next = 1'b0;
        move_prev = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        spawn = 1'b0; move_next = 1'b0; move_prev = 1'b0; golpe = 1'b0;
        #1;
        check("rst_rgb", 32'(rgb), 32'(rst_rgb));
        check("rst_score", 32'(score), 32'd0);
        check("rst_misses", 32'(misses), 32'd0);
        check("rst_sel", 32'(sel_idx), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_ack", 32'(spawn_ack), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int m0;
        int h0;
        for (int k = 0; k < N; k++) rst_rgb[3*k +: 3] = (k == 0) ? 3'b001 : 3'b010;
        #2;
        apply_reset();

        // cursor wrap and cancelling pulses
        move_prev = 1'b1; tick();
        check("wrap_prev", 32'(sel_idx), 32'd3);
        move_next = 1'b1; tick();
        check("wrap_next", 32'(sel_idx), 32'd0);
        move_next = 1'b1; move_prev = 1'b1; tick();
        check("both_moves", 32'(sel_idx), 32'd0);

        // spawn on cell 2, walk the cursor to it, strike
        spawn = 1'b1; spawn_idx = 3'd2; tick();
        check("spawn2_ack", 32'(spawn_ack), 32'd1);
        move_next = 1'b1; tick();
        move_next = 1'b1; tick();
        golpe = 1'b1; tick();
        check("first_hit", 32'(hit), 32'd1);
        check("first_score", 32'(score), 32'd1);
        golpe = 1'b0;
        idle(6);

        // held button on an empty cell: a single miss, no hit
        m0 = int'(misses);
        h0 = hit_seen;
        golpe = 1'b1;
        idle(20);
        check("held_miss", 32'(misses), 32'(m0 + 1));
        check("held_nohit", 32'(hit_seen), 32'(h0));
        golpe = 1'b0; tick();

        // mole lifetime on cell 1
        m0 = int'(misses);
        spawn = 1'b1; spawn_idx = 3'd1; tick();
`ifdef MOLE_TIMEOUT_EN
        idle(LIFE);
        check("expiry_miss", 32'(misses), 32'(m0 + 1));
        tick();
        check("expired_rgb", 32'(rgb[5:3]), 32'h2);
`else
        idle(100);
        check("still_up", 32'(rgb[5:3]), 32'h6);
        check("no_expiry", 32'(misses), 32'(m0));
`endif

        // rejected spawns
        spawn = 1'b1; spawn_idx = 3'd3; tick();
        check("spawn3_ack", 32'(spawn_ack), 32'd1);
        spawn = 1'b1; spawn_idx = 3'd3; tick();
        check("spawn3_busy", 32'(spawn_ack), 32'd0);
        spawn = 1'b1; spawn_idx = 3'd7; tick();
        check("spawn7_range", 32'(spawn_ack), 32'd0);

        // random play
        for (int i = 0; i < 500; i++) begin
            spawn     = ($urandom_range(0, 2) == 0);
            spawn_idx = IW'($urandom_range(0, 7));
            move_next = ($urandom_range(0, 3) == 0);
            move_prev = ($urandom_range(0, 3) == 0);
            golpe     = ($urandom_range(0, 2) != 0);
            tick();
        end
        golpe = 1'b0; tick();

        // score saturation, then reset while a cell flashes
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            spawn = 1'b1; spawn_idx = 3'd0; tick();
            golpe = 1'b1; tick();
            golpe = 1'b0; idle(5);
        end
        check("score_sat", 32'(score), 32'd15);
        spawn = 1'b1; spawn_idx = 3'd0; tick();
        golpe = 1'b1; tick();
        golpe = 1'b0; tick();
        #2;
        apply_reset();
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
